serial_subtractor: RTL and testbench

//   Bit-serial, LSB-first N-bit subtractor computing diff = a - b over WIDTH cycles.

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 35 +++
 rtl/full_subtractor.sv | 26 ++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks.
//   state_t   : sequencer states for serial_subtractor
//   MAX_WIDTH : largest operand width the serial datapath supports
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_if.sv
// Host <-> serial_subtractor handshake bundle.
//   start, a, b                       : host -> subtractor (request + operands)
//   busy, done, diff, borrow_out      : subtractor -> host (status + result)
//   overflow                          : subtractor -> host, only when SUB_OVF_EN is defined
// Modports: master (host controller), slave (subtractor).
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SUB_OVF_EN
   logic             overflow;
`endif

   modport master (
      output start, a, b,
`ifdef SUB_OVF_EN
      input  overflow,
`endif
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
`ifdef SUB_OVF_EN
      output overflow,
`endif
      output busy, done, diff, borrow_out
   );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives.
//   a, b   : minuend / subtrahend bits
//   b_in   : incoming borrow
//   diff   : a ^ b ^ b_in
//   b_out  : (~a & b) | (~(a ^ b) & b_in)
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic b_in,
   output logic diff,
   output logic b_out
);
   logic a_x_b;
   logic a_n;
   logic axb_n;
   logic brw_gen;
   logic brw_prop;

   xor g_x1 (a_x_b, a, b);
   xor g_x2 (diff, a_x_b, b_in);
   not g_n1 (a_n, a);
   not g_n2 (axb_n, a_x_b);
   and g_a1 (brw_gen, a_n, b);
   and g_a2 (brw_prop, axb_n, b_in);
   or  g_o1 (b_out, brw_gen, brw_prop);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b mod 2^WIDTH over WIDTH shift cycles,
// using one full_subtractor cell and a registered borrow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_subtractor_if.slave (start/a/b in; busy/done/diff/borrow_out out)
// Parameter WIDTH : operand width, 1..MAX_WIDTH.
// Optional macro SUB_OVF_EN : adds a registered signed-overflow flag (bus.overflow).
//
// state | meaning
// IDLE  | waiting for start; result outputs hold last value
// SHIFT | one operand bit per cycle through the cell, WIDTH cycles
// DONE  | publish borrow (and overflow), pulse done on exit
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("serial_subtractor: WIDTH out of range");
   end

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_r;
   logic [WIDTH-1:0] diff_shift;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic             busy_r;
   logic             done_r;
   logic             borrow_out_r;
   logic             cell_d;
   logic             cell_bout;

   full_subtractor u_cell (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .b_in  (borrow),
      .diff  (cell_d),
      .b_out (cell_bout)
   );

   // New result bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB.
   if (WIDTH == 1) begin : g_diff_w1
      assign diff_shift = cell_d;
   end else begin : g_diff_wn
      assign diff_shift = {cell_d, diff_r[WIDTH-1:1]};
   end

`ifdef SUB_OVF_EN
   // Operand MSBs are shifted out of the registers, so keep copies for the flag.
   logic a_msb;
   logic b_msb;
   logic overflow_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_sr         <= '0;
         b_sr         <= '0;
         diff_r       <= '0;
         cnt          <= '0;
         borrow       <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         borrow_out_r <= 1'b0;
`ifdef SUB_OVF_EN
         a_msb        <= 1'b0;
         b_msb        <= 1'b0;
         overflow_r   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  diff_r <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
`ifdef SUB_OVF_EN
                  a_msb  <= bus.a[WIDTH-1];
                  b_msb  <= bus.b[WIDTH-1];
`endif
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               diff_r <= diff_shift;
               borrow <= cell_bout;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done_r       <= 1'b1;
               busy_r       <= 1'b0;
               borrow_out_r <= borrow;
`ifdef SUB_OVF_EN
               overflow_r   <= (a_msb ^ b_msb) & (a_msb ^ diff_r[WIDTH-1]);
`endif
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.diff       = diff_r;
   assign bus.borrow_out = borrow_out_r;
`ifdef SUB_OVF_EN
   assign bus.overflow   = overflow_r;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=8 instance plus a WIDTH=1 instance.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   // reference model
   function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
      int r;
      r = (int'(a) - int'(b) + 256) % 256;
      return r[7:0];
   endfunction
   function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
      return int'(a) < int'(b);
   endfunction
   function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b);
      int sa, sb, r;
      sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
      sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
      r  = sa - sb;
      return (r > 127) || (r < -128);
   endfunction

   // Drives one operation on the 8-bit instance; returns done latency (edges
   // after acceptance, 0 = timeout) and the outputs seen in the done cycle.
   // Operands are scrambled right after acceptance.
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b, output int lat,
                         output logic [7:0] d, output logic bo, output logic ov);
      lat = 0; d = '0; bo = 1'b0; ov = 1'b0;
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = a; bus8.b = b;
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus8.done) begin
            lat = c; d = bus8.diff; bo = bus8.borrow_out;
`ifdef SUB_OVF_EN
            ov = bus8.overflow;
`endif
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_total++; if (bus8.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus8.busy); else n_pass++;
      n_total++; if (bus8.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus8.done); else n_pass++;
      n_total++; if (bus8.diff !== 8'h00) $display("FAIL reset_diff got=%h exp=00", bus8.diff); else n_pass++;
      n_total++; if (bus8.borrow_out !== 1'b0) $display("FAIL reset_borrow got=%b exp=0", bus8.borrow_out); else n_pass++;
`ifdef SUB_OVF_EN
      n_total++; if (bus8.overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus8.overflow); else n_pass++;
`endif
      n_total++; if (bus1.diff !== 1'b0) $display("FAIL reset_diff_w1 got=%b exp=0", bus1.diff); else n_pass++;
   endtask

   task automatic test_directed;
      logic [7:0] va [3] = '{8'h35, 8'h12, 8'h80};
      logic [7:0] vb [3] = '{8'h12, 8'h35, 8'h01};
      int lat; logic [7:0] d; logic bo, ov;
      for (int i = 0; i < 3; i++) begin
         do_op8(va[i], vb[i], lat, d, bo, ov);
         n_total++; if (lat !== 9) $display("FAIL dir_latency[%0d] got=%0d exp=9", i, lat); else n_pass++;
         n_total++; if (d !== ref_diff(va[i], vb[i])) $display("FAIL dir_diff[%0d] got=%h exp=%h", i, d, ref_diff(va[i], vb[i])); else n_pass++;
         n_total++; if (bo !== ref_borrow(va[i], vb[i])) $display("FAIL dir_borrow[%0d] got=%b exp=%b", i, bo, ref_borrow(va[i], vb[i])); else n_pass++;
`ifdef SUB_OVF_EN
         n_total++; if (ov !== ref_ovf(va[i], vb[i])) $display("FAIL dir_ovf[%0d] got=%b exp=%b", i, ov, ref_ovf(va[i], vb[i])); else n_pass++;
`endif
         // done is a single pulse and the result holds afterwards
         @(negedge clk);
         n_total++; if (bus8.done !== 1'b0) $display("FAIL dir_done_pulse[%0d] got=%b exp=0", i, bus8.done); else n_pass++;
         @(negedge clk);
         n_total++; if (bus8.diff !== ref_diff(va[i], vb[i])) $display("FAIL dir_hold[%0d] got=%h exp=%h", i, bus8.diff, ref_diff(va[i], vb[i])); else n_pass++;
      end
   endtask

   task automatic test_ignore_start;
      int n_done = 0;
      logic [7:0] d = '0;
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h35; bus8.b = 8'h12;
      @(negedge clk);
      bus8.start = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 2) begin bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; end
         if (c == 3) bus8.start = 1'b0;
         if (bus8.done) begin n_done++; d = bus8.diff; end
      end
      n_total++; if (n_done !== 1) $display("FAIL ignore_done_count got=%0d exp=1", n_done); else n_pass++;
      n_total++; if (d !== 8'h23) $display("FAIL ignore_diff got=%h exp=23", d); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int n_done = 0;
      int lat; logic [7:0] d; logic bo, ov;
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h35;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_total++; if (bus8.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus8.busy); else n_pass++;
      n_total++; if (bus8.diff !== 8'h00) $display("FAIL midrst_diff got=%h exp=00", bus8.diff); else n_pass++;
      n_total++; if (bus8.borrow_out !== 1'b0) $display("FAIL midrst_borrow got=%b exp=0", bus8.borrow_out); else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bus8.done) n_done++;
      end
      n_total++; if (n_done !== 0) $display("FAIL midrst_no_done got=%0d exp=0", n_done); else n_pass++;
      do_op8(8'h00, 8'h00, lat, d, bo, ov);
      n_total++; if (lat !== 9) $display("FAIL midrst_fresh_lat got=%0d exp=9", lat); else n_pass++;
      n_total++; if (d !== 8'h00) $display("FAIL midrst_fresh_diff got=%h exp=00", d); else n_pass++;
      n_total++; if (bo !== 1'b0) $display("FAIL midrst_fresh_borrow got=%b exp=0", bo); else n_pass++;
   endtask

   task automatic test_width1;
      logic [1:0] va [3] = '{2'd0, 2'd1, 2'd1};
      logic [1:0] vb [3] = '{2'd1, 2'd0, 2'd1};
      for (int i = 0; i < 3; i++) begin
         int lat = 0;
         logic d = 1'b0, bo = 1'b0;
         @(negedge clk);
         bus1.start = 1'b1; bus1.a = va[i][0]; bus1.b = vb[i][0];
         @(posedge clk);
         @(negedge clk);
         bus1.start = 1'b0; bus1.a = ~va[i][0]; bus1.b = ~vb[i][0];
         for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.done) begin lat = c; d = bus1.diff; bo = bus1.borrow_out; break; end
         end
         n_total++; if (lat !== 2) $display("FAIL w1_latency[%0d] got=%0d exp=2", i, lat); else n_pass++;
         n_total++; if (d !== 1'(int'(va[i]) - int'(vb[i]))) $display("FAIL w1_diff[%0d] got=%b exp=%b", i, d, 1'(int'(va[i]) - int'(vb[i]))); else n_pass++;
         n_total++; if (bo !== (va[i] < vb[i])) $display("FAIL w1_borrow[%0d] got=%b exp=%b", i, bo, (va[i] < vb[i])); else n_pass++;
      end
   endtask

   // Back-to-back random operations: each new start follows the done cycle directly.
   task automatic test_random;
      int lat; logic [7:0] d; logic bo, ov;
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] a, b;
         a = 8'($urandom);
         b = 8'($urandom);
         if (i % 10 == 0) b = a;
         do_op8(a, b, lat, d, bo, ov);
         n_total++; if (lat !== 9) $display("FAIL rnd_latency a=%h b=%h got=%0d exp=9", a, b, lat); else n_pass++;
         n_total++; if (d !== ref_diff(a, b)) $display("FAIL rnd_diff a=%h b=%h got=%h exp=%h", a, b, d, ref_diff(a, b)); else n_pass++;
         n_total++; if (bo !== ref_borrow(a, b)) $display("FAIL rnd_borrow a=%h b=%h got=%b exp=%b", a, b, bo, ref_borrow(a, b)); else n_pass++;
`ifdef SUB_OVF_EN
         n_total++; if (ov !== ref_ovf(a, b)) $display("FAIL rnd_ovf a=%h b=%h got=%b exp=%b", a, b, ov, ref_ovf(a, b)); else n_pass++;
`endif
      end
   endtask

   initial begin
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      test_directed;
      test_ignore_start;
      test_reset_mid;
      test_width1;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
